// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor sequencer driving one external 1-bit full-subtractor slice, LSB first.
// Optional macro SERIAL_SUB_OVF_EN adds a signed-overflow output `ovf`.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic             fs_a,
    output logic             fs_b,
    output logic             fs_bin,
    input  logic             fs_d,
    input  logic             fs_bout,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   a_sr_r;
    logic [WIDTH-1:0]   b_sr_r;
    logic [WIDTH-2:0]   res_r;
    logic               brw_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   diff_r;
    logic               bout_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   res_next_s;

`ifdef SERIAL_SUB_OVF_EN
    logic               a_msb_r;
    logic               b_msb_r;
    logic               ovf_r;

    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic d_msb);
        ovf_calc = (a_msb != b_msb) && (d_msb != a_msb);
    endfunction
`endif

    // The newest slice bit enters at the top; the full word is only copied to diff at the end.
    assign res_next_s = {fs_d, res_r};

    // Shift registers are zero outside RUN, so the slice drive is 0 whenever idle.
    assign fs_a   = a_sr_r[0];
    assign fs_b   = b_sr_r[0];
    assign fs_bin = brw_r;
    assign diff   = diff_r;
    assign bout   = bout_r;
    assign busy   = busy_r;
    assign done   = done_r;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_r;
`endif

    // Sequencer FSM with all datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            a_sr_r  <= {WIDTH{1'b0}};
            b_sr_r  <= {WIDTH{1'b0}};
            res_r   <= {(WIDTH-1){1'b0}};
            brw_r   <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            diff_r  <= {WIDTH{1'b0}};
            bout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sr_r  <= a_in;
                        b_sr_r  <= b_in;
                        brw_r   <= bin;
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_r <= a_in[WIDTH-1];
                        b_msb_r <= b_in[WIDTH-1];
`endif
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_sr_r <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r <= {1'b0, b_sr_r[WIDTH-1:1]};
                    res_r  <= res_next_s[WIDTH-1:1];
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        // Final bit: publish the whole word and park the borrow drive at 0.
                        diff_r  <= res_next_s;
                        bout_r  <= fs_bout;
                        brw_r   <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_r   <= ovf_calc(a_msb_r, b_msb_r, fs_d);
`endif
                    end else begin
                        brw_r   <= fs_bout;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: behavioural full-subtractor slice plus a result scoreboard.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         bin = 1'b0;
    logic         fs_a, fs_b, fs_bin, fs_d, fs_bout;
    logic [W-1:0] diff;
    logic         bout, busy, done;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
        logic         o;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] held_diff = '0;
    logic         held_bout = 1'b0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_in(a_in), .b_in(b_in), .bin(bin),
        .fs_a(fs_a), .fs_b(fs_b), .fs_bin(fs_bin),
        .fs_d(fs_d), .fs_bout(fs_bout),
        .diff(diff), .bout(bout), .busy(busy), .done(done)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    // Gate-level full subtractor slice.
    assign fs_d    = fs_a ^ fs_b ^ fs_bin;
    assign fs_bout = (~fs_a & fs_b) | (~fs_a & fs_bin) | (fs_b & fs_bin);

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        logic [W:0] t;
        exp_t       e;
        t   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        e.d = t[W-1:0];
        e.b = t[W];
        e.o = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if ({fs_a, fs_b, fs_bin, diff, bout, busy, done} !== {(W+6){1'b0}}) begin
            failures++;
            $display("FAIL reset_outputs got fs=%b%b%b diff=%h bout=%b busy=%b done=%b exp all 0",
                     fs_a, fs_b, fs_bin, diff, bout, busy, done);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf got %b exp 0", ovf);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete operation with latency, hold and result checks.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        exp_t e;
        bit   seen;
        @(negedge clk);
        a_in = a; b_in = b; bin = bi; start = 1'b1;
        sb_q.push_back(model(a, b, bi));
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || fs_a !== a[0] || fs_b !== b[0] || fs_bin !== bi) begin
            failures++;
            $display("FAIL first_run_cycle got busy=%b fs=%b%b%b exp busy=1 fs=%b%b%b",
                     busy, fs_a, fs_b, fs_bin, a[0], b[0], bi);
        end
        seen = 1'b0;
        for (int k = 1; k <= W + 4; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (k != W) begin
                    failures++;
                    $display("FAIL done_edge got %0d exp %0d", k, W);
                end
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_at_done got %b exp 0", busy);
                end
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL scoreboard_empty got done with no expected entry");
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if (diff !== e.d || bout !== e.b) begin
                        failures++;
                        $display("FAIL result a=%0d b=%0d bin=%b got diff=%h bout=%b exp diff=%h bout=%b",
                                 a, b, bi, diff, bout, e.d, e.b);
                    end
`ifdef SERIAL_SUB_OVF_EN
                    checks++;
                    if (ovf !== e.o) begin
                        failures++;
                        $display("FAIL ovf a=%h b=%h got %b exp %b", a, b, ovf, e.o);
                    end
`endif
                    held_diff = e.d;
                    held_bout = e.b;
                end
                break;
            end else begin
                checks++;
                if (busy !== 1'b1 || diff !== held_diff || bout !== held_bout) begin
                    failures++;
                    $display("FAIL run_hold edge=%0d got busy=%b diff=%h bout=%b exp busy=1 diff=%h bout=%b",
                             k, busy, diff, bout, held_diff, held_bout);
                end
            end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL done_timeout got no done within %0d edges exp done at edge %0d", W + 4, W);
            sb_q.delete();
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {fs_a, fs_b, fs_bin} !== 3'b000) begin
            failures++;
            $display("FAIL after_done got done=%b busy=%b fs=%b%b%b exp all 0",
                     done, busy, fs_a, fs_b, fs_bin);
        end
    endtask

    task automatic test_basic();
        do_op(8'd100, 8'd37, 1'b0);
        do_op(8'd5,   8'd9,  1'b0);
        do_op(8'd0,   8'd0,  1'b1);
        do_op(8'h80,  8'h01, 1'b0);
        do_op(8'h7F,  8'hFF, 1'b1);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   dones;
        @(negedge clk);
        a_in = 8'd150; b_in = 8'd23; bin = 1'b1; start = 1'b1;
        sb_q.push_back(model(8'd150, 8'd23, 1'b1));
        sb_q.push_back(model(8'd12, 8'd200, 1'b0));
        dones = 0;
        @(posedge clk); #1;
        a_in = 8'd12; b_in = 8'd200; bin = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin
                a_in = 8'hA5; b_in = 8'h3C; bin = 1'b1;
            end
            if (k == 9) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_gap_busy got %b exp 0", busy);
                end
                a_in = 8'd12; b_in = 8'd200; bin = 1'b0;
            end
            if (k == 10) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_restart_busy got %b exp 1", busy);
                end
            end
            if (done === 1'b1) begin
                dones++;
                checks++;
                if (k != (dones == 1 ? W : 2 * W + 2)) begin
                    failures++;
                    $display("FAIL b2b_done_edge got %0d exp %0d", k, (dones == 1 ? W : 2 * W + 2));
                end
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b2b_scoreboard_empty got extra done at edge %0d", k);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if (diff !== e.d || bout !== e.b) begin
                        failures++;
                        $display("FAIL b2b_result got diff=%h bout=%b exp diff=%h bout=%b",
                                 diff, bout, e.d, e.b);
                    end
                    held_diff = e.d;
                    held_bout = e.b;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (dones != 2) begin
            failures++;
            $display("FAIL b2b_done_count got %0d exp 2", dones);
        end
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        a_in = 8'd100; b_in = 8'd37; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({fs_a, fs_b, fs_bin, diff, bout, busy, done} !== {(W+6){1'b0}}) begin
            failures++;
            $display("FAIL abort_outputs got fs=%b%b%b diff=%h bout=%b busy=%b done=%b exp all 0",
                     fs_a, fs_b, fs_bin, diff, bout, busy, done);
        end
        held_diff = '0;
        held_bout = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_done edge=%0d got done=%b busy=%b exp 0 0", k, done, busy);
            end
        end
        do_op(8'd200, 8'd55, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
